// File: rtl/score_display.sv
// Score field for the VGA overlay: binary score to BCD by double-dabble,
// then three 3x5 glyphs scaled by 2^SCALE_LOG2 with leading-zero blanking.
module score_display #(
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] score,
    input  logic       frame_start,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       pixel_on,
    output logic       busy,
    output logic [3:0] digit_h,
    output logic [3:0] digit_t,
    output logic [3:0] digit_o
);

    localparam int SCALE = 1 << SCALE_LOG2;

    localparam logic [10:0] X0_W    = 11'(X0);
    localparam logic [10:0] Y0_W    = 11'(Y0);
    localparam logic [10:0] GLYPH_W = 11'(3 * SCALE);
    localparam logic [10:0] GLYPH_H = 11'(5 * SCALE);
    localparam logic [10:0] XS_T    = 11'(X0 + 4 * SCALE);
    localparam logic [10:0] XS_O    = 11'(X0 + 8 * SCALE);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  digit_h_q, digit_t_q, digit_o_q;
    logic        commit_en;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;

    logic [10:0] hx, vy;
    logic        show_h, show_t;
    logic        pixel_d, pixel_q;

    // Add 3 to every nibble that would reach 10 or more after the shift.
    function automatic logic [11:0] dabble(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
        return r;
    endfunction

    // 3x5 font, top row in bits [14:12], leftmost column is the MSB of a row.
    function automatic logic [14:0] font(input logic [3:0] d);
        logic [14:0] g;
        case (d)
            4'd0:    g = 15'b111_101_101_101_111;
            4'd1:    g = 15'b010_110_010_010_111;
            4'd2:    g = 15'b111_001_111_100_111;
            4'd3:    g = 15'b111_001_111_001_111;
            4'd4:    g = 15'b101_101_111_001_001;
            4'd5:    g = 15'b111_100_111_001_111;
            4'd6:    g = 15'b111_100_111_101_111;
            4'd7:    g = 15'b111_001_001_001_001;
            4'd8:    g = 15'b111_101_111_101_111;
            4'd9:    g = 15'b111_101_111_001_111;
            default: g = 15'b000_000_000_000_000;
        endcase
        return g;
    endfunction

    // Lit pixel of digit d whose box starts at column xs, or 0 outside it.
    function automatic logic glyph_px(
        input logic [10:0] xs,
        input logic [10:0] x,
        input logic [10:0] y,
        input logic [3:0]  d
    );
        logic [10:0] dx;
        logic [10:0] dy;
        logic [1:0]  col;
        logic [2:0]  row;
        logic [3:0]  idx;
        logic [15:0] g;
        logic        hit;
        dx  = x - xs;
        dy  = y - Y0_W;
        col = 2'(dx >> SCALE_LOG2);
        row = 3'(dy >> SCALE_LOG2);
        idx = 4'd14 - 4'(row) * 4'd3 - 4'(col);
        g   = {1'b0, font(d)};
        hit = (x >= xs) && (x < xs + GLYPH_W) &&
              (y >= Y0_W) && (y < Y0_W + GLYPH_H);
        return hit & g[idx];
    endfunction

    // Conversion sequencer: latch, eight dabble-and-shift steps, commit.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        commit_en = 1'b0;
        bcd_adj   = bcd_q;
        shifted   = '0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    bin_d   = score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_adj = dabble(bcd_q);
                shifted = {bcd_adj, bin_q} << 1;
                bcd_d   = shifted[19:8];
                bin_d   = shifted[7:0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, working registers and the committed digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            digit_h_q <= '0;
            digit_t_q <= '0;
            digit_o_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            if (commit_en) begin
                digit_h_q <= bcd_q[11:8];
                digit_t_q <= bcd_q[7:4];
                digit_o_q <= bcd_q[3:0];
            end
        end
    end

    // Glyph lookup for the current beam position from committed digits only.
    always_comb begin
        hx      = {1'b0, hpos};
        vy      = {1'b0, vpos};
        show_h  = (digit_h_q != 4'd0);
        show_t  = show_h || (digit_t_q != 4'd0);
        pixel_d = (show_h && glyph_px(X0_W, hx, vy, digit_h_q)) ||
                  (show_t && glyph_px(XS_T, hx, vy, digit_t_q)) ||
                  glyph_px(XS_O, hx, vy, digit_o_q);
    end

    // One-cycle registered pixel output.
    always_ff @(posedge clk) begin
        if (reset) pixel_q <= 1'b0;
        else       pixel_q <= pixel_d;
    end

    assign pixel_on = pixel_q;
    assign busy     = (state_q != IDLE);
    assign digit_h  = digit_h_q;
    assign digit_t  = digit_t_q;
    assign digit_o  = digit_o_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: randomized conversions and pixel probes,
// checked by a queue-based scoreboard against an arithmetic model.
module tb_score_display;

    localparam int X0 = 16;
    localparam int Y0 = 16;
    localparam int SL = 2;
    localparam int S  = 1 << SL;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] score = '0;
    logic       frame_start = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       pixel_on;
    logic       busy;
    logic [3:0] digit_h, digit_t, digit_o;

    score_display #(.X0(X0), .Y0(Y0), .SCALE_LOG2(SL)) dut (
        .clk(clk),
        .reset(reset),
        .score(score),
        .frame_start(frame_start),
        .hpos(hpos),
        .vpos(vpos),
        .pixel_on(pixel_on),
        .busy(busy),
        .digit_h(digit_h),
        .digit_t(digit_t),
        .digit_o(digit_o)
    );

    always #20 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] dig_q[$];
    bit          pix_q[$];
    logic        pix_req = 1'b0;
    logic        pix_chk = 1'b0;

    int cur_h = 0, cur_t = 0, cur_o = 0;

    bit [2:0] fnt [10][5] = '{
        '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
        '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
        '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
        '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
        '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
        '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
    };

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic bit px_model(input int h, input int v,
                                    input int dh, input int dt, input int dn);
        int  d[3];
        bit  show[3];
        int  xs, col, row;
        d[0] = dh; d[1] = dt; d[2] = dn;
        show[0] = (dh != 0);
        show[1] = (dh != 0) || (dt != 0);
        show[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            xs = X0 + k * 4 * S;
            if (h >= xs && h < xs + 3 * S && v >= Y0 && v < Y0 + 5 * S) begin
                col = (h - xs) / S;
                row = (v - Y0) / S;
                if (show[k] && fnt[d[k]][row][2 - col]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Monitor: checks pixels one cycle after each probe and digits at commit.
    always @(posedge clk) pix_chk <= pix_req;

    logic        prev_busy = 1'b0;
    int          bcnt = 0;
    logic [11:0] mon_dig = '0;

    always @(negedge clk) begin
        logic [11:0] e;
        if (reset) begin
            prev_busy = 1'b0;
            bcnt      = 0;
            mon_dig   = '0;
        end else begin
            if (pix_chk) begin
                if (pix_q.size() == 0) chk("pix_underflow", 1, 0);
                else chk("pixel_on", pixel_on, pix_q.pop_front());
            end
            if (busy) begin
                bcnt++;
                chk("digits_hold", {digit_h, digit_t, digit_o}, mon_dig);
            end else if (prev_busy) begin
                chk("busy_len", bcnt, 9);
                if (dig_q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = dig_q.pop_front();
                    chk("digits", {digit_h, digit_t, digit_o}, e);
                    mon_dig = e;
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int h, input int v, input bit exp);
        hpos    = 10'(h);
        vpos    = 10'(v);
        pix_req = 1'b1;
        pix_q.push_back(exp);
    endtask

    task automatic rand_probe;
        int h, v;
        h = $urandom_range(X0 - 4, X0 + 12 * S + 4);
        v = $urandom_range(Y0 - 4, Y0 + 5 * S + 4);
        probe(h, v, px_model(h, v, cur_h, cur_t, cur_o));
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic set_cur(input int s);
        cur_h = s / 100;
        cur_t = (s / 10) % 10;
        cur_o = s % 10;
    endtask

    task automatic convert(input int s, input bit noise);
        pix_req     = 1'b0;
        score       = 8'(s);
        frame_start = 1'b1;
        dig_q.push_back(bcd_of(s));
        tick;
        for (int c = 0; c < 8; c++) begin
            pix_req     = 1'b0;
            frame_start = 1'b0;
            if (noise && c < 7) begin
                score       = 8'($urandom);
                frame_start = 1'($urandom_range(0, 1));
            end
            if (c < 6 && $urandom_range(0, 1) == 1) rand_probe();
            tick;
        end
        pix_req     = 1'b0;
        frame_start = 1'b0;
        wait_idle();
        set_cur(s);
    endtask

    task automatic idle_probes(input int n);
        for (int i = 0; i < n; i++) begin
            rand_probe();
            tick;
        end
        pix_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_vals[8] = '{0, 9, 10, 99, 100, 109, 199, 250};

        // Reset, with the beam parked on a pixel that would be lit.
        reset = 1'b1;
        hpos  = 10'(X0 + 32);
        vpos  = 10'(Y0);
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_pixel", pixel_on, 0);
        chk("rst_digits", {digit_h, digit_t, digit_o}, 12'h000);
        reset = 1'b0;
        tick;

        // 255 -> 2/5/5
        convert(255, 1'b0);
        chk("d255", {digit_h, digit_t, digit_o}, 12'h255);
        idle_probes(8);

        // 7: hundreds blank, ones top row lit
        convert(7, 1'b0);
        probe(X0 + 1, Y0, 1'b0);
        tick;
        probe(X0 + 32, Y0, 1'b1);
        tick;
        pix_req = 1'b0;

        // 1: column pattern 010, gap column dark
        convert(1, 1'b0);
        probe(X0 + 32, Y0, 1'b0);
        tick;
        probe(X0 + 36, Y0, 1'b1);
        tick;
        probe(X0 + 12, Y0, 1'b0);
        tick;
        pix_req = 1'b0;

        // 100 with score change and extra frame_start during CONVERT
        score       = 8'd100;
        frame_start = 1'b1;
        dig_q.push_back(bcd_of(100));
        tick;
        frame_start = 1'b0;
        tick;
        score       = 8'd42;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        wait_idle();
        set_cur(100);
        chk("d100", {digit_h, digit_t, digit_o}, 12'h100);
        repeat (12) tick;
        chk("no_second_conv", busy, 0);
        idle_probes(6);

        // Reset in the middle of converting 200
        score       = 8'd200;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        tick;
        tick;
        reset = 1'b1;
        tick;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_digits", {digit_h, digit_t, digit_o}, 12'h000);
        reset = 1'b0;
        set_cur(0);
        tick;
        convert(99, 1'b0);
        chk("d099", {digit_h, digit_t, digit_o}, 12'h099);
        idle_probes(6);

        // Boundary scores
        foreach (edge_vals[i]) begin
            convert(edge_vals[i], 1'b1);
            idle_probes(4);
        end

        // Random scores with noise on score/frame_start during conversion
        for (int i = 0; i < 25; i++) begin
            convert($urandom_range(0, 255), 1'b1);
            idle_probes(6);
        end

        tick;
        tick;
        chk("dig_q_empty", dig_q.size(), 0);
        chk("pix_q_empty", pix_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
